data_mem_rv: RTL and testbench
==============================

DATA_MEM_RV -- requirements
Module: data_mem_rv

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; legal values 32 or 64.
REQ-002 Parameter DEPTH, default 1024: number of words; power of two, >= 4.
REQ-003 Derived constants: BYTES = DATA_WIDTH/8; ADDR_WIDTH = log2(DEPTH*BYTES), the byte-address width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_WIDTH=64).
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_wdata  input  DATA_WIDTH  store data, right-justified.
REQ-013 resp_valid  output  1  response present.
REQ-014 resp_ready  input  1  response consumed this cycle when resp_valid is also high.
REQ-015 resp_rdata  output  DATA_WIDTH  load data, right-justified and extended; 0 for stores and errors.
REQ-016 resp_err  output  1  access rejected.

Function
REQ-017 The block SHALL use a two-state machine, CLEAR and RUN, with a clear counter of log2(DEPTH) bits.
REQ-018 CLEAR: the block SHALL write zero to word[counter] each cycle and increment the counter. After writing word DEPTH-1 it SHALL enter RUN, so CLEAR lasts exactly DEPTH cycles.
REQ-019 req_ready SHALL equal (state==RUN) && (!resp_valid || resp_ready), giving one access per cycle under full flow.
REQ-020 Request acceptance SHALL be the cycle in which req_valid && req_ready.
REQ-021 For an accepted request, resp_valid SHALL rise on the next edge, giving a latency of 1 cycle.
REQ-022 resp_valid, resp_rdata and resp_err SHALL hold stable while resp_valid && !resp_ready.
REQ-023 resp_valid SHALL clear on the edge where the response is consumed and no new request is accepted.
REQ-024 Word index SHALL be req_addr[ADDR_WIDTH-1:log2(BYTES)]. The byte lane offset SHALL be the low log2(BYTES) bits.
REQ-025 Stores SHALL write only the addressed byte lanes, taking them from the low bits of req_wdata. Other lanes of the word SHALL be unchanged.
REQ-026 Loads SHALL shift the addressed lanes down to bit 0, then sign- or zero-extend them to DATA_WIDTH according to req_unsigned.
REQ-027 A load accepted in the cycle after a store to the same word SHALL return the newly written data.
REQ-028 req_size=11 with DATA_WIDTH=32 SHALL be an error: no write, rdata 0, resp_err 1.
REQ-029 Requests presented during CLEAR SHALL be ignored, not queued.

Reset
REQ-030 When rst is high at a clock edge, the block SHALL set state=CLEAR, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0; this applies in any state, including mid-CLEAR (counter restarts) and with a response pending (response discarded).
REQ-031 req_ready SHALL be 0 while rst is high and for DEPTH cycles after rst falls.
REQ-032 Memory contents SHALL be defined (zero) only after CLEAR completes.

Configuration
REQ-033 The macro DMEM_MISALIGN_ERR_EN SHALL control misaligned-access handling.
REQ-034 With DMEM_MISALIGN_ERR_EN defined, an access whose address is not a multiple of its size SHALL perform no write and SHALL respond with resp_err=1 and resp_rdata=0.
REQ-035 Without DMEM_MISALIGN_ERR_EN, the offset bits below the access size SHALL be forced to zero (naturally aligned access), resp_err SHALL be set only under REQ-028, and no misalignment logic SHALL be present.

Verification
REQ-036 Clear check: DEPTH=16; assert rst 1 cycle -> req_ready low for exactly 16 cycles; then load word at 0x3C returns 0x00000000.
REQ-037 Byte store and sign extension: store word 0x11223344 at 0x10, then store byte 0xF0 at 0x11 -> signed byte load at 0x11 returns 0xFFFFFFF0, unsigned returns 0x000000F0, word load at 0x10 returns 0x1122F044.
REQ-038 Backpressure: load issued with resp_ready=0 for 3 cycles -> resp_valid held with stable data and req_ready low, then released after 1 consumed cycle.
REQ-039 Back-to-back traffic: store then load to the same address in consecutive cycles with resp_ready=1 -> second response equals stored data; one response per cycle.
REQ-040 Misalignment: half load at 0x03 -> resp_err=1 and rdata=0 with DMEM_MISALIGN_ERR_EN; without it, the access goes to 0x02 and resp_err=0.
REQ-041 Mid-operation reset: rst asserted while resp_valid=1 and also at CLEAR cycle 5 -> resp_valid=0 next cycle; CLEAR restarts and completes after a full DEPTH cycles.

Source files
------------

// File: rtl/data_mem_rv.sv
// Byte-addressable data memory with valid/ready request and response channels and a zeroing CLEAR phase after reset.
// Define DMEM_MISALIGN_ERR_EN to reject misaligned accesses; otherwise low offset bits are forced to natural alignment.
module data_mem_rv #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH * BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SB_W  = $clog2(DATA_WIDTH);
  localparam logic [6:0] DW7 = 7'(DATA_WIDTH);
  localparam logic IS32 = (DATA_WIDTH == 32);
  localparam logic CLEAR = 1'b0;
  localparam logic RUN   = 1'b1;

  logic                  state;
  logic [IDX_W-1:0]      clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  do_write;
  logic                  err;
  logic [IDX_W-1:0]      idx;
  logic [OFF_W-1:0]      off_raw;
  logic [OFF_W-1:0]      off;
  logic [OFF_W-1:0]      size_mask;
  logic [7:0]            lane_mask;
  logic [BYTES-1:0]      byte_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] ext_mask;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic [6:0]            nbits;
  logic [SB_W-1:0]       sign_pos;

  assign req_ready = (state == RUN) && !rst && (!resp_valid || resp_ready);
  assign accept    = req_valid && req_ready;

  // Address decode, lane selection and load extension for the request on the bus
  always_comb begin
    idx       = req_addr[ADDR_WIDTH-1:OFF_W];
    off_raw   = req_addr[OFF_W-1:0];
    size_mask = OFF_W'(3'd7 >> (2'd3 - req_size));
`ifdef DMEM_MISALIGN_ERR_EN
    off = off_raw;
    err = (IS32 && (req_size == 2'b11)) || (|(off_raw & size_mask));
`else
    off = off_raw & ~size_mask;
    err = IS32 && (req_size == 2'b11);
`endif
    lane_mask = 8'hFF >> (4'd8 - (4'd1 << req_size));
    byte_en   = BYTES'(lane_mask) << off;
    wdata_sh  = req_wdata << {off, 3'b000};
    rd_sh     = mem[idx] >> {off, 3'b000};
    nbits     = 7'd8 << req_size;
    sign_pos  = SB_W'(nbits - 7'd1);
    if (nbits >= DW7) begin
      ext_mask = '1;
    end else begin
      ext_mask = ~({DATA_WIDTH{1'b1}} << nbits);
    end
    if (!req_unsigned && rd_sh[sign_pos]) begin
      load_val = (rd_sh & ext_mask) | ~ext_mask;
    end else begin
      load_val = rd_sh & ext_mask;
    end
    if (req_we || err) begin
      rdata_next = '0;
    end else begin
      rdata_next = load_val;
    end
    do_write = accept && req_we && !err;
  end

  // CLEAR walks the counter through every word, then hands over to RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + IDX_W'(1);
      if (clr_cnt == IDX_W'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Memory array: zero fill during CLEAR, byte-lane stores during RUN
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) begin
      mem[clr_cnt] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (byte_en[i]) begin
          mem[idx][i*8 +: 8] <= wdata_sh[i*8 +: 8];
        end
      end
    end
  end

  // Response register: loads on acceptance, holds under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_rdata <= rdata_next;
      resp_err   <= err;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_rv.sv
// Scoreboard bench for data_mem_rv (DATA_WIDTH=32, DEPTH=16) with a byte-array reference model.
module tb_data_mem_rv;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic req_unsigned = 1'b0;
  logic resp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [1:0] req_size = 2'b00;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stalls = 0;
  int resp_cnt = 0;
  bit rand_ready = 1'b0;
  logic [32:0] exp_q[$];
  logic [7:0] mem_m [64];

  data_mem_rv #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: little-endian byte array, rules taken straight from the access definition
  function automatic logic [32:0] model(input logic we, input logic [AW-1:0] addr,
                                        input logic [1:0] size, input logic uns,
                                        input logic [31:0] wd);
    int nb = 1 << size;
    int a = int'(addr);
    logic [63:0] v = 64'h0;
    if (size == 2'b11) return {1'b1, 32'h0};
`ifdef DMEM_MISALIGN_ERR_EN
    if (a % nb != 0) return {1'b1, 32'h0};
`else
    a = a - (a % nb);
`endif
    if (we) begin
      for (int k = 0; k < nb; k++) mem_m[a+k] = wd[8*k +: 8];
      return 33'h0;
    end
    for (int k = 0; k < nb; k++) v = v | (64'(mem_m[a+k]) << (8*k));
    if (!uns && v[8*nb-1]) v = v | ~((64'h1 << (8*nb)) - 64'h1);
    return {1'b0, v[31:0]};
  endfunction

  // Monitor: pop and compare every consumed response
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata %0h with empty queue", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("resp_err", 64'(resp_err), 64'(e[32]));
        check("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present a request and hold it until accepted; leaves req_valid high on return
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd,
                       input bit use_c = 1'b0, input logic [32:0] c = 33'h0);
    int wait_n = 0;
    logic [32:0] e;
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    @(negedge clk);
    while (req_ready !== 1'b1) begin
      wait_n++;
      if (wait_n > 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got no acceptance, required within 200 cycles");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (wait_n > 0) stalls++;
    e = model(we, a, sz, uns, wd);
    if (use_c) e = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One reset edge, then measure how long req_ready stays low
  task automatic do_reset();
    int n = 0;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("ready_in_reset", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    @(negedge clk);
    check("reset_resp_valid", 64'(resp_valid), 64'h0);
    check("reset_resp_rdata", 64'(resp_rdata), 64'h0);
    check("reset_resp_err", 64'(resp_err), 64'h0);
    while (req_ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("clear_len", 64'(n), 64'(DEPTH));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int rc0;
    do_reset();

    // Cleared memory reads zero
    issue(1'b0, 6'h3C, 2'b10, 1'b0, 32'h0, 1'b1, 33'h0);
    idle(1);

    // Byte store with sign/zero extension
    issue(1'b1, 6'h10, 2'b10, 1'b0, 32'h11223344);
    issue(1'b1, 6'h11, 2'b00, 1'b0, 32'h000000F0);
    issue(1'b0, 6'h11, 2'b00, 1'b0, 32'h0, 1'b1, {1'b0, 32'hFFFFFFF0});
    issue(1'b0, 6'h11, 2'b00, 1'b1, 32'h0, 1'b1, {1'b0, 32'h000000F0});
    issue(1'b0, 6'h10, 2'b10, 1'b0, 32'h0, 1'b1, {1'b0, 32'h1122F044});
    idle(2);

    // Backpressure: response held three cycles, then consumed once
    resp_ready = 1'b0;
    issue(1'b0, 6'h10, 2'b10, 1'b0, 32'h0, 1'b1, {1'b0, 32'h1122F044});
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(resp_valid), 64'h1);
      check("bp_rdata", 64'(resp_rdata), 64'h1122F044);
      check("bp_ready", 64'(req_ready), 64'h0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_release", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_valid_clear", 64'(resp_valid), 64'h0);
    @(posedge clk);
    #1;

    // Back-to-back store/load and random full-flow traffic
    st = stalls;
    rc0 = resp_cnt;
    issue(1'b1, 6'h20, 2'b10, 1'b0, 32'hCAFEBABE);
    issue(1'b0, 6'h20, 2'b10, 1'b0, 32'h0, 1'b1, {1'b0, 32'hCAFEBABE});
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), 2'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), $urandom);
    idle(3);
    check("b2b_no_stall", 64'(stalls - st), 64'h0);
    check("b2b_resp_count", 64'(resp_cnt - rc0), 64'd42);

    // Misaligned half load
    issue(1'b1, 6'h00, 2'b10, 1'b0, 32'h8899AABB);
`ifdef DMEM_MISALIGN_ERR_EN
    issue(1'b0, 6'h03, 2'b01, 1'b0, 32'h0, 1'b1, {1'b1, 32'h0});
`else
    issue(1'b0, 6'h03, 2'b01, 1'b0, 32'h0, 1'b1, {1'b0, 32'hFFFF8899});
`endif
    // Doubleword size is illegal at this width
    issue(1'b1, 6'h08, 2'b11, 1'b0, 32'h12345678, 1'b1, {1'b1, 32'h0});
    issue(1'b0, 6'h08, 2'b10, 1'b0, 32'h0);
    idle(2);

    // Randomized traffic with random response backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom);
    req_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    // Reset with a response pending, then reset again mid-CLEAR
    resp_ready = 1'b0;
    issue(1'b0, 6'h20, 2'b10, 1'b0, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    check("pending_before_reset", 64'(resp_valid), 64'h1);
    @(posedge clk);
    #1;
    do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    issue(1'b0, 6'h20, 2'b10, 1'b0, 32'h0, 1'b1, 33'h0);
    issue(1'b0, 6'h11, 2'b00, 1'b0, 32'h0, 1'b1, 33'h0);
    idle(3);
    check("final_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
